// File: rtl/date_pkg.sv
// date_pkg: BCD calendar constants, FSM state type and digit helpers shared by
// the date counter and the date-set path.
package date_pkg;

    localparam logic [7:0] M_JAN = 8'h01;
    localparam logic [7:0] M_FEB = 8'h02;
    localparam logic [7:0] M_MAR = 8'h03;
    localparam logic [7:0] M_APR = 8'h04;
    localparam logic [7:0] M_MAY = 8'h05;
    localparam logic [7:0] M_JUN = 8'h06;
    localparam logic [7:0] M_JUL = 8'h07;
    localparam logic [7:0] M_AUG = 8'h08;
    localparam logic [7:0] M_SEP = 8'h09;
    localparam logic [7:0] M_OCT = 8'h10;
    localparam logic [7:0] M_NOV = 8'h11;
    localparam logic [7:0] M_DEC = 8'h12;

    localparam logic [7:0] DIM_28 = 8'h28;
    localparam logic [7:0] DIM_29 = 8'h29;
    localparam logic [7:0] DIM_30 = 8'h30;
    localparam logic [7:0] DIM_31 = 8'h31;

    typedef enum logic {RUN, CLAMP} state_t;

    function automatic logic [3:0] bcd_fix(input logic [3:0] d);
        return d > 4'd9 ? 4'd0 : d;
    endfunction

    // Two-digit BCD increment; 99 wraps to 00 so it can chain into wider counts.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v[3:0] != 4'd9 ? {v[7:4], v[3:0] + 4'd1} :
               v[7:4] != 4'd9 ? {v[7:4] + 4'd1, 4'd0} : 8'h00;
    endfunction

    function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
        return (!t[0] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
               ( t[0] && (u == 4'd2 || u == 4'd6));
    endfunction

    // Century years are leap only when the century digits are divisible by 4.
    function automatic logic is_leap_bcd(input logic [15:0] y);
        return y[7:0] != 8'h00 ? div4(y[7:4], y[3:0]) : div4(y[15:12], y[11:8]);
    endfunction

endpackage

// File: rtl/date_dim_lut.sv
// date_dim_lut: days in a BCD month for a BCD year; also used by date-set
// validation.
module date_dim_lut
    import date_pkg::*;
(
    input  logic [7:0]  month,
    input  logic [15:0] year,
    output logic [7:0]  dim
);

    always_comb begin
        dim = month == M_FEB ? (is_leap_bcd(year) ? DIM_29 : DIM_28) :
              month inside {M_APR, M_JUN, M_SEP, M_NOV} ? DIM_30 :
              month inside {M_JAN, M_MAR, M_MAY, M_JUL, M_AUG, M_OCT, M_DEC} ? DIM_31 :
              DIM_31;
    end

endmodule

// File: rtl/date_counter.sv
// date_counter: BCD day/month/year counter with range-checked load and one-cycle
// day clamp. DATE_COUNTER_WEEKDAY_EN adds a settable weekday counter.
module date_counter
    import date_pkg::*;
#(
    parameter logic [15:0] INIT_YEAR  = 16'h2000,
    parameter logic [7:0]  INIT_MONTH = 8'h01,
    parameter logic [7:0]  INIT_DAY   = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       load,
    input  logic [3:0] year_set3,
    input  logic [3:0] year_set2,
    input  logic [3:0] year_set1,
    input  logic [3:0] year_set0,
    input  logic [3:0] month_set1,
    input  logic [3:0] month_set0,
    input  logic [3:0] day_set1,
    input  logic [3:0] day_set0,
`ifdef DATE_COUNTER_WEEKDAY_EN
    input  logic [2:0] weekday_set,
    output logic [2:0] weekday,
`endif
    output logic [3:0] year3,
    output logic [3:0] year2,
    output logic [3:0] year1,
    output logic [3:0] year0,
    output logic [3:0] month1,
    output logic [3:0] month0,
    output logic [3:0] day1,
    output logic [3:0] day0,
    output logic       date_valid
);

    state_t      state, state_nxt;
    logic [15:0] year;
    logic [7:0]  month, day, dim, month_ld;
    logic        tick_pend, do_load, do_tick;

    date_dim_lut u_dim (.month(month), .year(year), .dim(dim));

    assign do_load  = state == RUN && load;
    assign do_tick  = state == RUN && !load && (day_tick || tick_pend);
    assign month_ld = {bcd_fix(month_set1), bcd_fix(month_set0)};

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == CLAMP ? RUN : (load ? CLAMP : RUN);
    end

    always_comb begin
        date_valid = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            year      <= INIT_YEAR;
            month     <= INIT_MONTH;
            day       <= INIT_DAY;
            tick_pend <= 1'b0;
        end else begin
            tick_pend <= state == CLAMP && day_tick;
            if (state == CLAMP) begin
                day <= day == 8'h00 ? 8'h01 : (day > dim ? dim : day);
            end else if (do_load) begin
                year  <= {bcd_fix(year_set3), bcd_fix(year_set2), bcd_fix(year_set1), bcd_fix(year_set0)};
                month <= (month_ld == 8'h00 || month_ld > M_DEC) ? M_JAN : month_ld;
                day   <= {bcd_fix(day_set1), bcd_fix(day_set0)};
            end else if (do_tick) begin
                if (day < dim) begin
                    day <= bcd_inc(day);
                end else begin
                    day <= 8'h01;
                    if (month == M_DEC) begin
                        month <= M_JAN;
                        year  <= {year[7:0] == 8'h99 ? bcd_inc(year[15:8]) : year[15:8], bcd_inc(year[7:0])};
                    end else begin
                        month <= bcd_inc(month);
                    end
                end
            end
        end
    end

`ifdef DATE_COUNTER_WEEKDAY_EN
    always_ff @(posedge clk) begin
        if (rst)          weekday <= 3'd6;
        else if (do_load) weekday <= weekday_set == 3'd7 ? 3'd0 : weekday_set;
        else if (do_tick) weekday <= weekday == 3'd6 ? 3'd0 : weekday + 3'd1;
    end
`endif

    assign {year3, year2, year1, year0} = year;
    assign {month1, month0}             = month;
    assign {day1, day0}                 = day;

endmodule
